z80_bus_pin_serializer: RTL and testbench

//  - Parametrised successor to the Z80 top-level pin multiplexer.
//  - Packs the CPU address bus and active-low control strobes into PIN_W output pins.
//  - Three slice-selection modes: manual, free-running auto-scan, and event snapshot.
//  - Adds per-strobe pulse stretching. Sits between the tv80s core and the uo_out pins.

---
 rtl/z80_bus_pin_serializer_pkg.sv | 32 +++
 rtl/z80_bus_pin_serializer_if.sv | 32 +++
 rtl/z80_bus_pin_serializer_strobe_stretch.sv | 36 +++
 rtl/z80_bus_pin_serializer.sv | 144 ++++++++++++++
 tb/tb_z80_bus_pin_serializer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/z80_bus_pin_serializer_pkg.sv
// Shared constants and helpers for the Z80 bus pin serializer slice.
package z80_bus_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MANUAL = 2'b00;
  localparam mode_t MODE_AUTO   = 2'b01;
  localparam mode_t MODE_SNAP   = 2'b10;
  localparam mode_t MODE_RSVD   = 2'b11;

  // Bit positions inside the active-low control strobe vector
  localparam int unsigned CTRL_M1    = 0;
  localparam int unsigned CTRL_MREQ  = 1;
  localparam int unsigned CTRL_IORQ  = 2;
  localparam int unsigned CTRL_RD    = 3;
  localparam int unsigned CTRL_WR    = 4;
  localparam int unsigned CTRL_RFSH  = 5;
  localparam int unsigned CTRL_HALT  = 6;
  localparam int unsigned CTRL_BUSAK = 7;

  function automatic int unsigned nslice(input int unsigned addr_w,
                                         input int unsigned ctrl_w,
                                         input int unsigned pin_w);
    return (addr_w + ctrl_w + pin_w - 1) / pin_w;
  endfunction

  // Slice-index width, never narrower than one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/z80_bus_pin_serializer_if.sv
// Bus-side interface of the pin serializer: live CPU bus in, pin slice out.
interface z80_bus_pin_serializer_if
  import z80_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned PIN_W  = 8,
  parameter int unsigned SEL_W  = sel_width(nslice(ADDR_W, CTRL_W, PIN_W))
);

  mode_t              mode;
  logic [SEL_W-1:0]   sel;
  logic [ADDR_W-1:0]  addr_in;
  logic [CTRL_W-1:0]  ctrl_n_in;
  logic               snap_ack;
  logic [PIN_W-1:0]   pins_out;
  logic [SEL_W-1:0]   slice_o;
  logic               frame_o;
  logic               snap_valid;
  logic               overrun;

  modport master (
    output mode, sel, addr_in, ctrl_n_in, snap_ack,
    input  pins_out, slice_o, frame_o, snap_valid, overrun
  );

  modport slave (
    input  mode, sel, addr_in, ctrl_n_in, snap_ack,
    output pins_out, slice_o, frame_o, snap_valid, overrun
  );

endinterface

// File: rtl/z80_bus_pin_serializer_strobe_stretch.sv
// Per-strobe pulse extender: masked active-low strobes stay low STRETCH cycles past release.
module z80_strobe_stretch #(
  parameter int unsigned       CTRL_W  = 8,
  parameter int unsigned       STRETCH = 1,
  parameter logic [CTRL_W-1:0] MASK    = 8'h0E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_n_in,
  output logic [CTRL_W-1:0] ctrl_s_c
);

  localparam int unsigned CNT_W = (STRETCH < 1) ? 1 : $clog2(STRETCH + 1);

  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_bit
    if (MASK[gi]) begin : g_str
      logic [CNT_W-1:0] cnt_q;

      // Reload while the strobe is low, count down after release
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (!ctrl_n_in[gi]) begin
          cnt_q <= CNT_W'(STRETCH);
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end

      assign ctrl_s_c[gi] = ctrl_n_in[gi] & (cnt_q == '0);
    end else begin : g_pass
      assign ctrl_s_c[gi] = ctrl_n_in[gi];
    end
  end

endmodule

// File: rtl/z80_bus_pin_serializer.sv
// Packs the Z80 address bus and stretched strobes onto PIN_W pins, one slice per cycle.
module z80_bus_pin_serializer
  import z80_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       CTRL_W       = 8,
  parameter int unsigned       PIN_W        = 8,
  parameter int unsigned       STRETCH      = 1,
  parameter logic [CTRL_W-1:0] STRETCH_MASK = 8'h0E,
  parameter int unsigned       TRIG_BIT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  z80_bus_pin_serializer_if.slave bus
);

  localparam int unsigned NSLICE = nslice(ADDR_W, CTRL_W, PIN_W);
  localparam int unsigned SEL_W  = sel_width(NSLICE);
  localparam int unsigned BUS_W  = ADDR_W + CTRL_W;
  localparam int unsigned VEC_W  = NSLICE * PIN_W;

  logic [CTRL_W-1:0] ctrl_s_c;
  logic [VEC_W-1:0]  vec_c;
  logic [VEC_W-1:0]  snap_q, snap_d;
  mode_t             mode_q;
  logic [SEL_W-1:0]  scan_q, scan_d, scan_c;
  logic              prev_trig_q;
  logic              trig_c, mode_chg_c;
  logic              sv_q, sv_d, ov_q, ov_d;
  logic [PIN_W-1:0]  pins_q, pins_d;
  logic [SEL_W-1:0]  slice_q, slice_d;
  logic              frame_q, frame_d;

  z80_strobe_stretch #(
    .CTRL_W  (CTRL_W),
    .STRETCH (STRETCH),
    .MASK    (STRETCH_MASK)
  ) u_stretch (
    .clk       (clk),
    .rst       (rst),
    .ctrl_n_in (bus.ctrl_n_in),
    .ctrl_s_c  (ctrl_s_c)
  );

  // Indices past the last slice read as an idle (all-ones) slice
  function automatic logic [PIN_W-1:0] get_slice(input logic [VEC_W-1:0] v,
                                                 input logic [SEL_W-1:0] idx);
    logic [PIN_W-1:0] s;
    s = '1;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == SEL_W'(k)) s = v[k*PIN_W +: PIN_W];
    end
    return s;
  endfunction

  always_comb begin
    vec_c            = '1;
    vec_c[BUS_W-1:0] = {ctrl_s_c, bus.addr_in};
  end

  assign trig_c     = prev_trig_q & ~bus.ctrl_n_in[TRIG_BIT];
  assign mode_chg_c = (bus.mode != mode_q);
  assign scan_c     = mode_chg_c ? '0 : scan_q;

  // Slice selection and snapshot bookkeeping for the current mode
  always_comb begin
    pins_d  = '1;
    slice_d = '0;
    frame_d = 1'b0;
    scan_d  = '0;
    sv_d    = sv_q;
    ov_d    = ov_q;
    snap_d  = snap_q;

    if (mode_chg_c) begin
      sv_d = 1'b0;
      ov_d = 1'b0;
    end

    unique case (bus.mode)
      MODE_MANUAL: begin
        pins_d  = get_slice(vec_c, bus.sel);
        slice_d = bus.sel;
      end
      MODE_AUTO: begin
        pins_d  = get_slice(vec_c, scan_c);
        slice_d = scan_c;
        frame_d = (scan_c == '0);
        scan_d  = (scan_c == SEL_W'(NSLICE - 1)) ? '0 : scan_c + SEL_W'(1);
      end
      MODE_SNAP: begin
        pins_d  = get_slice(sv_q ? snap_q : vec_c, bus.sel);
        slice_d = bus.sel;
        if (!mode_chg_c) begin
          if (trig_c) begin
            if (!sv_q || bus.snap_ack) begin
              snap_d = vec_c;
              sv_d   = 1'b1;
              ov_d   = 1'b0;
            end else begin
              ov_d   = 1'b1;
            end
          end else if (bus.snap_ack) begin
            sv_d = 1'b0;
            ov_d = 1'b0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_MANUAL;
      scan_q      <= '0;
      prev_trig_q <= 1'b1;
      sv_q        <= 1'b0;
      ov_q        <= 1'b0;
      snap_q      <= '1;
      pins_q      <= '1;
      slice_q     <= '0;
      frame_q     <= 1'b0;
    end else begin
      mode_q      <= bus.mode;
      scan_q      <= scan_d;
      prev_trig_q <= bus.ctrl_n_in[TRIG_BIT];
      sv_q        <= sv_d;
      ov_q        <= ov_d;
      snap_q      <= snap_d;
      pins_q      <= pins_d;
      slice_q     <= slice_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.pins_out   = pins_q;
  assign bus.slice_o    = slice_q;
  assign bus.frame_o    = frame_q;
  assign bus.snap_valid = sv_q;
  assign bus.overrun    = ov_q;

endmodule

// File: tb/tb_z80_bus_pin_serializer.sv
// Directed bench with a cycle-level reference model of the pin serializer.
module tb_z80_bus_pin_serializer;

  localparam logic [7:0] MASK    = 8'h0E;
  localparam int         STRETCH = 1;
  localparam int         NSL     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  z80_bus_pin_serializer_if #(.ADDR_W(16), .CTRL_W(8), .PIN_W(8), .SEL_W(2)) bus_if ();

  z80_bus_pin_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  logic [7:0]  exp_pins;
  logic [1:0]  exp_slice;
  logic        exp_frame, exp_sv, exp_ov;
  logic        model_ready = 1'b0;
  int          cyc = 0;
  int          auto_base = 0;
  int          last_low [8];
  logic        prev_trig, held, ovr;
  logic [1:0]  mode_prev;
  logic [31:0] snap_data;

  function automatic logic [7:0] byte_of(input logic [31:0] x, input int k);
    return 8'(x >> (8 * k));
  endfunction

  always @(posedge clk) begin
    logic [7:0]  s;
    logic [31:0] v, src;
    logic        trig, chg;
    int          k;
    if (rst) begin
      exp_pins = 8'hFF; exp_slice = 2'd0; exp_frame = 1'b0;
      exp_sv = 1'b0; exp_ov = 1'b0;
      held = 1'b0; ovr = 1'b0; prev_trig = 1'b1; mode_prev = 2'b00;
      for (int i = 0; i < 8; i++) last_low[i] = -100;
      model_ready = 1'b1;
    end else begin
      cyc++;
      s = bus_if.ctrl_n_in;
      for (int i = 0; i < 8; i++) begin
        if (!bus_if.ctrl_n_in[i]) last_low[i] = cyc;
        if (MASK[i] && (cyc - last_low[i] <= STRETCH)) s[i] = 1'b0;
      end
      v    = {8'hFF, s, bus_if.addr_in};
      trig = prev_trig && !bus_if.ctrl_n_in[1];
      prev_trig = bus_if.ctrl_n_in[1];
      chg  = (bus_if.mode != mode_prev);
      mode_prev = bus_if.mode;
      if (chg) begin held = 1'b0; ovr = 1'b0; auto_base = cyc; end
      exp_pins = 8'hFF; exp_slice = 2'd0; exp_frame = 1'b0;
      case (bus_if.mode)
        2'b00: begin
          exp_slice = bus_if.sel;
          if (int'(bus_if.sel) < NSL) exp_pins = byte_of(v, int'(bus_if.sel));
        end
        2'b01: begin
          k = (cyc - auto_base) % NSL;
          exp_pins  = byte_of(v, k);
          exp_slice = 2'(k);
          exp_frame = (k == 0);
        end
        2'b10: begin
          exp_slice = bus_if.sel;
          src = held ? snap_data : v;
          if (int'(bus_if.sel) < NSL) exp_pins = byte_of(src, int'(bus_if.sel));
          if (!chg) begin
            if (trig) begin
              if (!held || bus_if.snap_ack) begin
                snap_data = v; held = 1'b1; ovr = 1'b0;
              end else begin
                ovr = 1'b1;
              end
            end else if (bus_if.snap_ack) begin
              held = 1'b0; ovr = 1'b0;
            end
          end
        end
        default: ;
      endcase
      exp_sv = held;
      exp_ov = ovr;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ready) begin
      vectors++;
      if (bus_if.pins_out !== exp_pins || bus_if.slice_o !== exp_slice ||
          bus_if.frame_o !== exp_frame || bus_if.snap_valid !== exp_sv ||
          bus_if.overrun !== exp_ov) begin
        fails++;
        $display("FAIL model t=%0t got pins=%h slice=%0d frame=%b sv=%b ov=%b want pins=%h slice=%0d frame=%b sv=%b ov=%b",
                 $time, bus_if.pins_out, bus_if.slice_o, bus_if.frame_o, bus_if.snap_valid,
                 bus_if.overrun, exp_pins, exp_slice, exp_frame, exp_sv, exp_ov);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bus_if.mode = 2'b00; bus_if.sel = 2'd0; bus_if.addr_in = 16'h0000;
    bus_if.ctrl_n_in = 8'hFF; bus_if.snap_ack = 1'b0;
    step(2);
    chk("rst_pins", bus_if.pins_out, 8'hFF);
    chk("rst_slice", 8'(bus_if.slice_o), 8'd0);
    chk("rst_sv_ov", {6'd0, bus_if.snap_valid, bus_if.overrun}, 8'd0);
    rst = 1'b0;

    // MANUAL slices of BEEF
    bus_if.addr_in = 16'hBEEF;
    bus_if.sel = 2'd0; step(); chk("man_s0", bus_if.pins_out, 8'hEF);
    bus_if.sel = 2'd1; step(); chk("man_s1", bus_if.pins_out, 8'hBE);
    bus_if.sel = 2'd2; step(); chk("man_s2", bus_if.pins_out, 8'hFF);
    bus_if.sel = 2'd3; step(); chk("man_s3", bus_if.pins_out, 8'hFF);
    chk("man_s3_slice", 8'(bus_if.slice_o), 8'd3);

    // AUTO scan of 1234
    bus_if.addr_in = 16'h1234; bus_if.mode = 2'b01;
    step(); chk("auto_0", bus_if.pins_out, 8'h34); chk("auto_f0", 8'(bus_if.frame_o), 8'd1);
    step(); chk("auto_1", bus_if.pins_out, 8'h12); chk("auto_f1", 8'(bus_if.frame_o), 8'd0);
    step(); chk("auto_2", bus_if.pins_out, 8'hFF); chk("auto_sl2", 8'(bus_if.slice_o), 8'd2);
    step(); chk("auto_3", bus_if.pins_out, 8'h34); chk("auto_f3", 8'(bus_if.frame_o), 8'd1);

    // Stretching on the ctrl slice
    bus_if.mode = 2'b00; bus_if.sel = 2'd2; step(2);
    bus_if.ctrl_n_in = 8'hF7; step(); chk("rd_low", bus_if.pins_out, 8'hF7);
    bus_if.ctrl_n_in = 8'hFF; step(); chk("rd_stretch", bus_if.pins_out, 8'hF7);
    step(); chk("rd_release", bus_if.pins_out, 8'hFF);
    bus_if.ctrl_n_in = 8'hEF; step(); chk("wr_low", bus_if.pins_out, 8'hEF);
    bus_if.ctrl_n_in = 8'hFF; step(); chk("wr_release", bus_if.pins_out, 8'hFF);

    // Snapshot capture and ack
    bus_if.mode = 2'b10; bus_if.sel = 2'd0; bus_if.addr_in = 16'hA55A; step(2);
    bus_if.ctrl_n_in = 8'hFD; step();
    bus_if.addr_in = 16'h0000; bus_if.ctrl_n_in = 8'hFF; step();
    chk("snap_sv", 8'(bus_if.snap_valid), 8'd1); chk("snap_s0", bus_if.pins_out, 8'h5A);
    bus_if.sel = 2'd1; step(); chk("snap_s1", bus_if.pins_out, 8'hA5);
    bus_if.sel = 2'd2; step(); chk("snap_s2", bus_if.pins_out, 8'hFD);
    bus_if.snap_ack = 1'b1; step(); bus_if.snap_ack = 1'b0;
    chk("snap_ack", 8'(bus_if.snap_valid), 8'd0);

    // Overrun, then trigger coincident with ack
    bus_if.sel = 2'd0; bus_if.addr_in = 16'h1111; bus_if.ctrl_n_in = 8'hFD; step();
    bus_if.ctrl_n_in = 8'hFF; step();
    bus_if.addr_in = 16'h2222; bus_if.ctrl_n_in = 8'hFD; step();
    bus_if.ctrl_n_in = 8'hFF; step();
    chk("ovr_set", 8'(bus_if.overrun), 8'd1); chk("ovr_keep", bus_if.pins_out, 8'h11);
    bus_if.snap_ack = 1'b1; step(); bus_if.snap_ack = 1'b0;
    chk("ovr_ack", {6'd0, bus_if.snap_valid, bus_if.overrun}, 8'd0);
    bus_if.addr_in = 16'h3333; bus_if.ctrl_n_in = 8'hFD; step();
    bus_if.ctrl_n_in = 8'hFF; step();
    bus_if.addr_in = 16'h4444; bus_if.ctrl_n_in = 8'hFD; bus_if.snap_ack = 1'b1; step();
    bus_if.ctrl_n_in = 8'hFF; bus_if.snap_ack = 1'b0; step();
    chk("coinc_pins", bus_if.pins_out, 8'h44);
    chk("coinc_sv_ov", {6'd0, bus_if.snap_valid, bus_if.overrun}, 8'd2);

    // Reserved mode
    bus_if.mode = 2'b11; step();
    chk("rsvd_pins", bus_if.pins_out, 8'hFF); chk("rsvd_frame", 8'(bus_if.frame_o), 8'd0);

    // Reset mid-AUTO
    bus_if.mode = 2'b01; bus_if.addr_in = 16'h1234; step(2);
    chk("auto_mid", 8'(bus_if.slice_o), 8'd1);
    rst = 1'b1; step();
    chk("rst_auto_pins", bus_if.pins_out, 8'hFF); chk("rst_auto_slice", 8'(bus_if.slice_o), 8'd0);
    rst = 1'b0; step(3);

    // Reset during held snapshot
    bus_if.mode = 2'b10; bus_if.sel = 2'd0; step(2);
    bus_if.ctrl_n_in = 8'hFD; step(); bus_if.ctrl_n_in = 8'hFF; step();
    chk("held_sv", 8'(bus_if.snap_valid), 8'd1);
    rst = 1'b1; step();
    chk("rst_snap_pins", bus_if.pins_out, 8'hFF);
    chk("rst_snap_sv_ov", {6'd0, bus_if.snap_valid, bus_if.overrun}, 8'd0);
    rst = 1'b0; step(3);
    chk("no_false_trig", 8'(bus_if.snap_valid), 8'd0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
